// File: rtl/vreg_issue_if.sv
// vreg_issue_if: instruction handshake, register-file selects and writeback bus of the issue controller
interface vreg_issue_if #(
    parameter int W = 64,
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_src1;
    logic [1:0]   in_src2;
    logic [1:0]   in_dst;
    logic         in_wb;
    logic [1:0]   voper1;
    logic [1:0]   voper2;
    logic         ex_valid;
    logic [W-1:0] res_data;
    logic         wEnable;
    logic [1:0]   vresult;
    logic [W-1:0] dataIn;
    logic [N-1:0] sb_mask;
    logic         busy;
    modport master (
        output in_valid, in_src1, in_src2, in_dst, in_wb, res_data,
        input  in_ready, voper1, voper2, ex_valid, wEnable, vresult, dataIn, sb_mask, busy
    );
    modport slave (
        input  in_valid, in_src1, in_src2, in_dst, in_wb, res_data,
        output in_ready, voper1, voper2, ex_valid, wEnable, vresult, dataIn, sb_mask, busy
    );
endinterface

// File: rtl/vreg_issue_ctrl.sv
// vreg_issue_ctrl: in-order vector issue with scoreboard hazard stall and fixed-latency writeback
module vreg_issue_ctrl #(
    parameter int elementSize = 8,
    parameter int vectorSize  = 8,
    parameter int vectors     = 4,
    parameter int latency     = 3
) (
    input logic         clk,
    input logic         rst,
    vreg_issue_if.slave bus
);
    localparam int W = elementSize * vectorSize;
    logic [latency-1:0] p_v, p_wb;
    logic [1:0]         p_dst [latency];
    logic [vectors-1:0] sb, set_m, clr_m;
    logic [1:0]         last1, last2;
    logic [W-1:0]       wdata;
    logic               hz, rdy, acc, wb_now;
    // hazard check, issue selects and writeback port drive
    always_comb begin
        hz          = sb[bus.in_src1] | sb[bus.in_src2] | (bus.in_wb & sb[bus.in_dst]);
        rdy         = !rst & !hz;
        acc         = bus.in_valid & rdy;
        wb_now      = !rst & p_v[latency-1] & p_wb[latency-1];
        set_m       = (acc & bus.in_wb) ? vectors'(1) << bus.in_dst : '0;
        clr_m       = wb_now ? vectors'(1) << p_dst[latency-1] : '0;
        wdata       = wb_now ? bus.res_data : '0;
        bus.in_ready = rdy;
        bus.ex_valid = acc;
        bus.voper1   = acc ? bus.in_src1 : last1;
        bus.voper2   = acc ? bus.in_src2 : last2;
        bus.wEnable  = wb_now;
        bus.vresult  = wb_now ? p_dst[latency-1] : 2'd0;
        bus.dataIn   = wdata;
        bus.sb_mask  = sb;
        bus.busy     = |p_v;
    end
    // execution pipeline tracking {valid, wb, dst} per stage
    always_ff @(posedge clk) begin
        if (rst) begin
            p_v  <= '0;
            p_wb <= '0;
            for (int i = 0; i < latency; i++) p_dst[i] <= 2'd0;
        end else begin
            p_v[0]   <= acc;
            p_wb[0]  <= acc & bus.in_wb;
            p_dst[0] <= bus.in_dst;
            for (int i = 1; i < latency; i++) begin
                p_v[i]   <= p_v[i-1];
                p_wb[i]  <= p_wb[i-1];
                p_dst[i] <= p_dst[i-1];
            end
        end
    end
    // scoreboard: issue set takes priority over writeback clear
    always_ff @(posedge clk) begin
        if (rst) sb <= '0;
        else     sb <= (sb & ~clr_m) | set_m;
    end
    // read selects hold the last issued operands between issues
    always_ff @(posedge clk) begin
        if (rst) begin
            last1 <= 2'd0;
            last2 <= 2'd0;
        end else if (acc) begin
            last1 <= bus.in_src1;
            last2 <= bus.in_src2;
        end
    end
endmodule

// File: tb/tb_vreg_issue_ctrl.sv
// tb_vreg_issue_ctrl: directed checks of issue, hazard stall, writeback and reset
module tb_vreg_issue_ctrl;
    logic clk, rst;
    int   total, bad;
    vreg_issue_if #(.W(64), .N(4)) bus ();
    vreg_issue_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic nc();
        @(posedge clk);
        #1;
    endtask
    task automatic drv(input logic v, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d, input logic wb);
        bus.in_valid = v;
        bus.in_src1  = s1;
        bus.in_src2  = s2;
        bus.in_dst   = d;
        bus.in_wb    = wb;
        #1;
    endtask
    // a set and a clear of the same register on one edge must never happen
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready && bus.in_wb && bus.wEnable)
            chk("set_clr_same_reg", 64'(bus.vresult == bus.in_dst), 64'd0);
    end
    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.res_data = 64'd0;
        drv(1'b1, 2'd0, 2'd1, 2'd2, 1'b1);
        nc();
        nc();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_wEnable", bus.wEnable, 0);
        rst = 1'b0;
        drv(1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
        chk("idle_sb", bus.sb_mask, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_vresult", bus.vresult, 0);
        chk("idle_dataIn", bus.dataIn, 0);
        chk("idle_voper1", bus.voper1, 0);
        chk("idle_voper2", bus.voper2, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 2'(i), 2'(3 - i), 2'(i), 1'b1);
            chk("idle_ready", bus.in_ready, 1);
        end
        // single instruction 0,1 -> 2
        bus.res_data = 64'h1122334455667788;
        nc();
        drv(1'b1, 2'd0, 2'd1, 2'd2, 1'b1);
        chk("t2_ex_valid", bus.ex_valid, 1);
        chk("t2_voper1", bus.voper1, 0);
        chk("t2_voper2", bus.voper2, 1);
        for (int c = 1; c <= 2; c++) begin
            nc();
            drv(1'b0, 2'd3, 2'd3, 2'd2, 1'b0);
            chk("t2_ready_nowb", bus.in_ready, 1);
            drv(1'b0, 2'd3, 2'd3, 2'd2, 1'b1);
            chk("t2_ready_waw", bus.in_ready, 0);
            chk("t2_sb", bus.sb_mask, 4'b0100);
            chk("t2_busy", bus.busy, 1);
            chk("t2_we_early", bus.wEnable, 0);
            chk("t2_voper2_hold", bus.voper2, 1);
        end
        nc();
        drv(1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
        chk("t2_we", bus.wEnable, 1);
        chk("t2_vresult", bus.vresult, 2);
        chk("t2_dataIn", bus.dataIn, 64'h1122334455667788);
        chk("t2_sb_wb", bus.sb_mask, 4'b0100);
        nc();
        chk("t2_we_after", bus.wEnable, 0);
        chk("t2_sb_after", bus.sb_mask, 0);
        chk("t2_busy_after", bus.busy, 0);
        chk("t2_dataIn_after", bus.dataIn, 0);
        // RAW: 0,1 -> 2 then 2,0 -> 3
        bus.res_data = 64'hCAFEF00D12345678;
        nc();
        drv(1'b1, 2'd0, 2'd1, 2'd2, 1'b1);
        chk("t3_issue0", bus.ex_valid, 1);
        for (int c = 1; c <= 3; c++) begin
            nc();
            drv(1'b1, 2'd2, 2'd0, 2'd3, 1'b1);
            chk("t3_stall_ready", bus.in_ready, 0);
            chk("t3_stall_ex", bus.ex_valid, 0);
        end
        chk("t3_we_c3", bus.wEnable, 1);
        chk("t3_vresult_c3", bus.vresult, 2);
        nc();
        chk("t3_ready_c4", bus.in_ready, 1);
        chk("t3_ex_c4", bus.ex_valid, 1);
        chk("t3_voper1_c4", bus.voper1, 2);
        chk("t3_voper2_c4", bus.voper2, 0);
        for (int c = 5; c <= 6; c++) begin
            nc();
            drv(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
            chk("t3_we_idle", bus.wEnable, 0);
            chk("t3_sb_idle", bus.sb_mask, 4'b1000);
        end
        nc();
        chk("t3_we_c7", bus.wEnable, 1);
        chk("t3_vresult_c7", bus.vresult, 3);
        chk("t3_dataIn_c7", bus.dataIn, 64'hCAFEF00D12345678);
        nc();
        chk("t3_busy_end", bus.busy, 0);
        chk("t3_sb_end", bus.sb_mask, 0);
        // WAW on reg 1 with an independent instruction to reg 2
        nc();
        drv(1'b1, 2'd0, 2'd0, 2'd1, 1'b1);
        chk("t4_issue0", bus.ex_valid, 1);
        nc();
        drv(1'b1, 2'd0, 2'd3, 2'd2, 1'b1);
        chk("t4_indep_ready", bus.in_ready, 1);
        chk("t4_indep_voper2", bus.voper2, 3);
        nc();
        drv(1'b1, 2'd0, 2'd0, 2'd1, 1'b1);
        chk("t4_waw_c2", bus.in_ready, 0);
        chk("t4_sb_c2", bus.sb_mask, 4'b0110);
        bus.res_data = 64'hA5A5A5A55A5A5A5A;
        nc();
        chk("t4_waw_c3", bus.in_ready, 0);
        chk("t4_we_c3", bus.wEnable, 1);
        chk("t4_vresult_c3", bus.vresult, 1);
        chk("t4_dataIn_c3", bus.dataIn, 64'hA5A5A5A55A5A5A5A);
        bus.res_data = 64'h0123456789ABCDEF;
        nc();
        #1;
        chk("t4_ready_c4", bus.in_ready, 1);
        chk("t4_ex_c4", bus.ex_valid, 1);
        chk("t4_we_c4", bus.wEnable, 1);
        chk("t4_vresult_c4", bus.vresult, 2);
        chk("t4_dataIn_c4", bus.dataIn, 64'h0123456789ABCDEF);
        nc();
        drv(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t4_sb_c5", bus.sb_mask, 4'b0010);
        nc();
        chk("t4_we_c6", bus.wEnable, 0);
        nc();
        chk("t4_we_c7", bus.wEnable, 1);
        chk("t4_vresult_c7", bus.vresult, 1);
        nc();
        chk("t4_busy_end", bus.busy, 0);
        // wb=0 instruction
        nc();
        drv(1'b1, 2'd1, 2'd2, 2'd0, 1'b0);
        chk("t5_ex", bus.ex_valid, 1);
        chk("t5_voper1", bus.voper1, 1);
        for (int c = 1; c <= 3; c++) begin
            nc();
            drv(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
            chk("t5_busy", bus.busy, 1);
            chk("t5_sb", bus.sb_mask, 0);
            chk("t5_we", bus.wEnable, 0);
        end
        nc();
        chk("t5_busy_end", bus.busy, 0);
        chk("t5_we_end", bus.wEnable, 0);
        // reset with two writes in flight
        nc();
        drv(1'b1, 2'd0, 2'd0, 2'd1, 1'b1);
        chk("t6_issue0", bus.ex_valid, 1);
        nc();
        drv(1'b1, 2'd0, 2'd0, 2'd2, 1'b1);
        chk("t6_issue1", bus.ex_valid, 1);
        nc();
        rst = 1'b1;
        drv(1'b1, 2'd3, 2'd3, 2'd3, 1'b1);
        chk("t6_rst_ready", bus.in_ready, 0);
        chk("t6_rst_ex", bus.ex_valid, 0);
        chk("t6_rst_we", bus.wEnable, 0);
        nc();
        rst = 1'b0;
        drv(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
        chk("t6_sb", bus.sb_mask, 0);
        chk("t6_busy", bus.busy, 0);
        for (int c = 0; c < 4; c++) begin
            chk("t6_no_we", bus.wEnable, 0);
            nc();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
